// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD counter / multiplexed 7-segment display.
// Holds the BCD digit type and the 16-entry segment lookup (active-high,
// segment a in bit 0, g in bit 6). Codes 10..15 decode to all segments off,
// so code 15 doubles as the "blank" selector.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEG_BLANK_CODE = 4'hF;

    // Element 15 first, element 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // 15..10 blank
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,         // 9..5
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F          // 4..0
    };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder.
// Ports:
//   digit_i : 4-bit code (0..9 digits, 10..15 blank)
//   seg_o   : active-high segments a..g, a in bit 0
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[digit_i];

endmodule

// File: rtl/bcd_mux_counter.sv
// Multi-digit BCD up/down counter with prescaled count tick, parallel load,
// terminal-count pulse and a time-multiplexed 7-segment display driver.
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   en       : count enable (gates the prescaler)
//   up_dn    : 1 = count up, 0 = count down
//   load     : synchronous load strobe (priority over a tick)
//   load_val : load value, one BCD nibble per digit, digit 0 in LSBs
//   bcd      : current count, same packing as load_val
//   tc       : one-cycle pulse after a wrapping count edge
//   seg      : segments a..g of the selected digit (polarity per ACTIVE_LOW)
//   an       : one-hot digit select (polarity per ACTIVE_LOW)
module bcd_mux_counter
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 1000000,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [BW-1:0]     bcd_q, bcd_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tc_q, tc_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              tick;
    logic [BW-1:0]     inc_val, dec_val, load_clamped;
    logic              carry, borrow;
    bcd_digit_t        d_cur;
    bcd_digit_t        digit_sel, dec_in;
    logic              nz_above, blank;

    assign tick = en && (pre_q == PRE_LAST);

    // Ripple carry/borrow across digits; a carry/borrow surviving past the
    // top digit marks the all-9 / all-0 wrap.
    always_comb begin
        inc_val      = bcd_q;
        dec_val      = bcd_q;
        load_clamped = load_val;
        carry        = 1'b1;
        borrow       = 1'b1;
        d_cur        = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d_cur = bcd_q[4*i +: 4];
            if (carry) begin
                if (d_cur >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = d_cur + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (d_cur == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = d_cur - 4'd1;
                    borrow            = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        if (load) begin
            bcd_d = load_clamped;
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
            if (up_dn) begin
                bcd_d = inc_val;
                tc_d  = carry;
            end else begin
                bcd_d = dec_val;
                tc_d  = borrow;
            end
        end else if (en) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_comb begin
        ref_d = ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Digit mux plus leading-zero detection: a digit is blanked when it and
    // every digit above it are zero, except digit 0.
    always_comb begin
        digit_sel = '0;
        an_d      = '0;
        nz_above  = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit_sel = bcd_q[4*i +: 4];
                an_d[i]   = 1'b1;
            end
            if ((IW'(i) >= idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
                nz_above = 1'b1;
            end
        end
        blank  = (LZ_BLANK != 0) && (idx_q != '0) && !nz_above;
        dec_in = blank ? SEG_BLANK_CODE : digit_sel;
    end

    bcd_to_7seg u_seg (
        .digit_i (dec_in),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
            ref_q <= '0;
            idx_q <= '0;
            an_q  <= DIGITS'(1);
            seg_q <= SEG_LUT[0];
        end else begin
            bcd_q <= bcd_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
            ref_q <= ref_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bcd = bcd_q;
    assign tc  = tc_q;
    assign seg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an  = (ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_bcd_mux_counter.sv
module tb_bcd_mux_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        en_a = 1'b0, up_a = 1'b1, load_a = 1'b0;
    logic [15:0] lv_a = '0;
    logic [15:0] bcd_a;
    logic        tc_a;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;

    logic        en_b = 1'b0, up_b = 1'b1, load_b = 1'b0;
    logic [15:0] lv_b = '0;
    logic [15:0] bcd_b;
    logic        tc_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_mux_counter #(
        .DIGITS(4), .PRESCALE(1), .REFRESH_DIV(2), .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_a (
        .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .load(load_a),
        .load_val(lv_a), .bcd(bcd_a), .tc(tc_a), .seg(seg_a), .an(an_a)
    );

    bcd_mux_counter #(
        .DIGITS(4), .PRESCALE(4), .REFRESH_DIV(2), .ACTIVE_LOW(1), .LZ_BLANK(0)
    ) u_b (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(load_b),
        .load_val(lv_b), .bcd(bcd_b), .tc(tc_b), .seg(seg_b), .an(an_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd4(input int unsigned v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial begin
        int         bad;
        int         tc_cnt;
        bit         found;
        logic [3:0] prev_an;
        logic [3:0] exp_an [8];
        logic [6:0] exp_seg_lz [8];
        logic [6:0] exp_seg_nz [8];

        exp_an     = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        // active-low: "2"=~5B=24, "4"=~66=19, "0"=~3F=40, blank=7F
        exp_seg_lz = '{7'h24, 7'h24, 7'h19, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        exp_seg_nz = '{7'h24, 7'h24, 7'h19, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40};

        // Reset applied before any clock edge: outputs must respond asynchronously.
        #2 rst = 1'b1;
        #1;
        chk("rst_bcd", 32'(bcd_a), 32'h0000);
        chk("rst_tc", 32'(tc_a), 32'h0);
        chk("rst_an", 32'(an_a), 32'hE);
        chk("rst_seg", 32'(seg_a), 32'h40);
        chk("rst_an_b", 32'(an_b), 32'hE);

        // Full up sweep with a tick every cycle.
        step();
        rst  = 1'b0;
        en_a = 1'b1;
        up_a = 1'b1;
        bad    = 0;
        tc_cnt = 0;
        for (int k = 1; k <= 10000; k++) begin
            step();
            if (bcd_a !== to_bcd4(k % 10000)) bad++;
            if (tc_a === 1'b1) tc_cnt++;
            if (k == 10000) begin
                chk("wrap_bcd", 32'(bcd_a), 32'h0000);
                chk("wrap_tc", 32'(tc_a), 32'h1);
            end
        end
        chk("sweep_bad_cycles", 32'(bad), 32'h0);
        chk("sweep_tc_pulses", 32'(tc_cnt), 32'h1);
        en_a = 1'b0;
        step();
        chk("hold_bcd", 32'(bcd_a), 32'h0000);
        chk("tc_one_cycle", 32'(tc_a), 32'h0);

        // Load zero, then count down across the wrap.
        load_a = 1'b1; lv_a = 16'h0000; up_a = 1'b0;
        step();
        chk("load0_bcd", 32'(bcd_a), 32'h0000);
        chk("load0_tc", 32'(tc_a), 32'h0);
        load_a = 1'b0; en_a = 1'b1;
        step();
        chk("dn_wrap_bcd", 32'(bcd_a), 32'h9999);
        chk("dn_wrap_tc", 32'(tc_a), 32'h1);
        step();
        chk("dn_next_bcd", 32'(bcd_a), 32'h9998);
        chk("dn_next_tc", 32'(tc_a), 32'h0);

        // Load with coincident tick, nibble clamping.
        load_a = 1'b1; lv_a = 16'h1F3A; up_a = 1'b1;
        step();
        chk("load_clamp_bcd", 32'(bcd_a), 32'h1939);
        chk("load_clamp_tc", 32'(tc_a), 32'h0);
        load_a = 1'b0; up_a = 1'b0;
        step();
        chk("dir_dn_bcd", 32'(bcd_a), 32'h1938);
        up_a = 1'b1;
        step();
        chk("dir_up_bcd", 32'(bcd_a), 32'h1939);
        en_a = 1'b0;

        // Display scan with leading-zero blanking.
        load_a = 1'b1; lv_a = 16'h0042;
        step();
        load_a  = 1'b0;
        found   = 1'b0;
        prev_an = an_a;
        for (int n = 0; n < 16 && !found; n++) begin
            step();
            if (an_a === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
            prev_an = an_a;
        end
        chk("scan_a_sync", 32'(found), 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk($sformatf("scan_a_an%0d", i), 32'(an_a), 32'(exp_an[i]));
            chk($sformatf("scan_a_seg%0d", i), 32'(seg_a), 32'(exp_seg_lz[i]));
        end

        // Asynchronous reset mid-cycle.
        load_a = 1'b1; lv_a = 16'h0573;
        step();
        load_a = 1'b0;
        chk("pre_rst_bcd", 32'(bcd_a), 32'h0573);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_bcd", 32'(bcd_a), 32'h0000);
        chk("async_rst_tc", 32'(tc_a), 32'h0);
        chk("async_rst_an", 32'(an_a), 32'hE);
        chk("async_rst_seg", 32'(seg_a), 32'h40);
        step();
        rst  = 1'b0;
        en_a = 1'b1; up_a = 1'b1;
        step();
        chk("resume_bcd1", 32'(bcd_a), 32'h0001);
        step();
        chk("resume_bcd2", 32'(bcd_a), 32'h0002);
        en_a = 1'b0;

        // Prescaler: load clears it, disabled cycles hold it.
        up_b = 1'b1; en_b = 1'b1;
        step();
        step();
        load_b = 1'b1; lv_b = 16'h0005;
        step();
        chk("b_load_bcd", 32'(bcd_b), 32'h0005);
        load_b = 1'b0;
        step(); step(); step();
        chk("b_3en_bcd", 32'(bcd_b), 32'h0005);
        en_b = 1'b0;
        step(); step();
        chk("b_hold_bcd", 32'(bcd_b), 32'h0005);
        en_b = 1'b1;
        step();
        chk("b_tick_bcd", 32'(bcd_b), 32'h0006);
        chk("b_tick_tc", 32'(tc_b), 32'h0);
        en_b = 1'b0;

        // Display scan without blanking.
        load_b = 1'b1; lv_b = 16'h0042;
        step();
        load_b  = 1'b0;
        found   = 1'b0;
        prev_an = an_b;
        for (int n = 0; n < 16 && !found; n++) begin
            step();
            if (an_b === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
            prev_an = an_b;
        end
        chk("scan_b_sync", 32'(found), 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk($sformatf("scan_b_an%0d", i), 32'(an_b), 32'(exp_an[i]));
            chk($sformatf("scan_b_seg%0d", i), 32'(seg_b), 32'(exp_seg_nz[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_mux_counter.md
BCD_MUX_COUNTER -- requirements
Module: bcd_mux_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 1000000: clk cycles per count tick, legal range 1..2^24.
REQ-003 Parameter REFRESH_DIV, default 1000: clk cycles per display digit slot, legal range 1..2^16.
REQ-004 Parameter ACTIVE_LOW, default 1: seg and an outputs are active-low when 1.
REQ-005 Parameter LZ_BLANK, default 1: leading-zero blanking enabled when 1.
REQ-006 Port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port en, input, 1 bit: count enable.
REQ-009 Port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-010 Port load, input, 1 bit: synchronous parallel load strobe.
REQ-011 Port load_val, input, 4*DIGITS bits: value to load, one BCD nibble per digit, digit 0 in the LSBs.
REQ-012 Port bcd, output, 4*DIGITS bits: current count, same packing as load_val.
REQ-013 Port tc, output, 1 bit: terminal-count pulse.
REQ-014 Port seg, output, 7 bits: segments a..g of the selected digit, a in bit 0.
REQ-015 Port an, output, DIGITS bits: one-hot digit select.

Function
REQ-016 The prescaler shall count 0..PRESCALE-1 while en=1, hold its value while en=0, and assert an internal tick in the cycle it equals PRESCALE-1 with en=1.
REQ-017 On each tick, the counter shall add 1 when up_dn=1 or subtract 1 when up_dn=0; bcd shall update on the clock edge that ends the tick cycle.
REQ-018 Up-count rule: digit 9 -> 0 with carry into the next digit; other digits +1.
REQ-019 Down-count rule: digit 0 -> 9 with borrow from the next digit; other digits -1.
REQ-020 Up-count wrap: all-9 -> all-0, with tc high for exactly the one cycle following the wrapping edge.
REQ-021 Down-count wrap: all-0 -> all-9, with tc high for exactly the one cycle following the wrapping edge.
REQ-022 tc shall not pulse on any other transition.
REQ-023 load=1 shall take priority over a tick in the same cycle.
REQ-024 On load, bcd shall equal load_val on the next cycle, except that any nibble >9 is clamped to 9.
REQ-025 load shall clear the prescaler to 0 and shall not pulse tc.
REQ-026 load shall act regardless of en.
REQ-027 A change of up_dn shall take effect at the next tick; no count is lost or duplicated.
REQ-028 The refresh counter shall run continuously (independent of en) and advance the digit index 0..DIGITS-1 cyclically every REFRESH_DIV cycles.
REQ-029 an shall be one-hot at the current digit index, inverted when ACTIVE_LOW=1.
REQ-030 seg shall be the 7-segment pattern of the selected digit, registered, aligned in the same cycle as an, and inverted when ACTIVE_LOW=1.
REQ-031 Leading-zero blanking: with LZ_BLANK=1, zero digits above the most significant nonzero digit shall show all segments off; digit 0 is never blanked.
REQ-032 If DIGITS=1, an shall be constantly asserted.

Reset
REQ-033 While rst=1, bcd, the prescaler, the refresh counter and the digit index shall be 0, and tc shall be 0.
REQ-034 While rst=1, an shall select digit 0, and seg shall show the pattern of "0" (polarity per ACTIVE_LOW).
REQ-035 Reset asserted mid-count or mid-load shall abort the operation immediately; the first tick after release shall occur PRESCALE cycles after release with en=1.

Structure
REQ-036 A shared package bcd_disp_pkg shall hold the 16-entry segment lookup constant (codes 10..15 blank) and the BCD digit type.
REQ-037 Segment decoding shall live in one combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-high out), instantiated once after the digit mux.

Verification
REQ-038 Scenario, DIGITS=4, PRESCALE=1, en=1, up_dn=1: reset, then 10000 cycles -> bcd steps 0000..9999, returns to 0000, tc pulses once, exactly at the 9999->0000 transition.
REQ-039 Scenario, load 0x0000, up_dn=0, one tick -> bcd=0x9999 and tc=1 for 1 cycle; a further tick gives 0x9998.
REQ-040 Scenario, load_val=0x1F3A with load and a tick in the same cycle -> bcd=0x1939 next cycle, no count applied, no tc.
REQ-041 Scenario, PRESCALE=4: en toggled 1,0,0,1 around the tick boundary -> ticks occur only after 4 cumulative enabled cycles; bcd increments once.
REQ-042 Scenario, REFRESH_DIV=2, ACTIVE_LOW=1, bcd=0x0042 -> an cycles 1110,1101,1011,0111 every 2 cycles; seg shows "2","4",blank,blank (LZ_BLANK=1) and "2","4","0","0" (LZ_BLANK=0).
REQ-043 Scenario: rst asserted asynchronously mid-cycle at bcd=0x0573 -> bcd=0, tc=0, an=1110 immediately without waiting for a clock edge; counting resumes from 0000 after release.
